nombre_scroller: RTL and testbench



---
 rtl/nombre_scroller_if.sv | 31 +++
 rtl/nombre_scroller.sv | 149 ++++++++++++++
 tb/tb_nombre_scroller.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nombre_scroller_if.sv
// Control and display bus between the name scroller and its environment.
// The slave side is the scroller itself: it takes the controls and drives the digit indices.
interface nombre_scroller_if;
    logic        en;
    logic        mode;
    logic        dir;
    logic        step;
    logic [15:0] digits;
    logic        tick;
    logic        wrap;

    modport slave (
        input  en,
        input  mode,
        input  dir,
        input  step,
        output digits,
        output tick,
        output wrap
    );

    modport master (
        output en,
        output mode,
        output dir,
        output step,
        input  digits,
        input  tick,
        input  wrap
    );
endinterface

// File: rtl/nombre_scroller.sv
// Scrolls a NAME_LEN-letter name across a four-digit 7-segment window.
// Each digit receives a letter index, or 4'hF for blank.
module nombre_scroller #(
    parameter int DIV      = 50000000,
    parameter int NAME_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    nombre_scroller_if.slave   bus
);

    localparam int              PW    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   TERM  = PW'(DIV - 1);
    localparam logic [3:0]      LAST  = 4'(NAME_LEN + 2);
    localparam logic signed [5:0] MAX_L = 6'(NAME_LEN - 1);

    // The letter index is formed in signed 6-bit arithmetic so that pos-k never aliases below zero.
    function automatic logic [15:0] f_window(input logic [3:0] pos);
        logic [15:0]       v;
        logic signed [5:0] l;
        v = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            l = $signed({2'b00, pos}) - $signed(6'(k));
            if ((l >= 6'sd0) && (l <= MAX_L)) begin
                v[4*k +: 4] = l[3:0];
            end else begin
                v[4*k +: 4] = 4'hF;
            end
        end
        return v;
    endfunction

    logic [PW-1:0] r_presc;
    logic [3:0]    r_pos;
    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic          r_tick;
    logic          r_wrap;
    logic [15:0]   r_digits;

    logic          w_term;
    logic          w_edge;
    logic          w_adv;
    logic [3:0]    w_pos_nxt;
    logic          w_wraps;

    // Advance decision and next position.
    always_comb begin
        w_term    = 1'b0;
        w_edge    = 1'b0;
        w_adv     = 1'b0;
        w_pos_nxt = r_pos;
        w_wraps   = 1'b0;

        w_term = (r_presc == TERM);
        w_edge = r_s2 & ~r_s3;

        if (bus.mode) begin
            w_adv = bus.en & w_edge;
        end else begin
            w_adv = bus.en & w_term;
        end

        if (bus.dir) begin
            if (r_pos == 4'd0) begin
                w_pos_nxt = LAST;
                w_wraps   = 1'b1;
            end else if (r_pos > LAST) begin
                w_pos_nxt = LAST;
                w_wraps   = 1'b0;
            end else begin
                w_pos_nxt = r_pos - 4'd1;
                w_wraps   = 1'b0;
            end
        end else begin
            if (r_pos >= LAST) begin
                w_pos_nxt = 4'd0;
                w_wraps   = 1'b1;
            end else begin
                w_pos_nxt = r_pos + 4'd1;
                w_wraps   = 1'b0;
            end
        end
    end

    // Step button synchronizer and edge-delay stage; keeps tracking even while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.step;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Auto-scroll prescaler and its terminal-count pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (bus.mode) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (bus.en) begin
            if (w_term) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_presc <= r_presc + PW'(1);
                r_tick  <= 1'b0;
            end
        end else begin
            r_presc <= r_presc;
            r_tick  <= 1'b0;
        end
    end

    // Window position and wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos  <= 4'd0;
            r_wrap <= 1'b0;
        end else if (w_adv) begin
            r_pos  <= w_pos_nxt;
            r_wrap <= w_wraps;
        end else begin
            r_pos  <= r_pos;
            r_wrap <= 1'b0;
        end
    end

    // Digit indices follow the position one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits <= 16'hFFF0;
        end else begin
            r_digits <= f_window(r_pos);
        end
    end

    assign bus.digits = r_digits;
    assign bus.tick   = r_tick;
    assign bus.wrap   = r_wrap;

endmodule

// File: tb/tb_nombre_scroller.sv
// Bench for nombre_scroller: two instances (DIV=4/NAME_LEN=8 and DIV=2/NAME_LEN=3) share stimulus,
// a cycle model checks both every cycle, and directed checks pin literal values.
module tb_nombre_scroller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, mode, dir, step;

    nombre_scroller_if bus_a();
    nombre_scroller_if bus_b();

    assign bus_a.en   = en;
    assign bus_a.mode = mode;
    assign bus_a.dir  = dir;
    assign bus_a.step = step;
    assign bus_b.en   = en;
    assign bus_b.mode = mode;
    assign bus_b.dir  = dir;
    assign bus_b.step = step;

    nombre_scroller #(.DIV(4), .NAME_LEN(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    nombre_scroller #(.DIV(2), .NAME_LEN(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Window contents from a position: digit k (3 = leftmost) shows letter pos-k if it exists.
    function automatic logic [15:0] window(input int pos, input int len);
        logic [15:0] r;
        int l;
        r = 16'h0000;
        for (int k = 3; k >= 0; k--) begin
            l = pos - k;
            r = {r[11:0], ((l >= 0) && (l < len)) ? 4'(l) : 4'hF};
        end
        return window_ret(r);
    endfunction

    function automatic logic [15:0] window_ret(input logic [15:0] v);
        return v;
    endfunction

    // Behavioural model state, one slot per instance.
    int          m_div [2] = '{4, 2};
    int          m_len [2] = '{8, 3};
    int          m_cnt [2];
    int          m_pos [2];
    logic [15:0] e_dig [2];
    logic        e_tick[2];
    logic        e_wrap[2];
    logic        hist  [3];
    bit          m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic edge_ev;
        int   c, p;
        logic t, w, adv;
        if (rst) begin
            hist    <= '{1'b0, 1'b0, 1'b0};
            m_valid <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i]  <= 0;
                m_pos[i]  <= 0;
                e_dig[i]  <= 16'hFFF0;
                e_tick[i] <= 1'b0;
                e_wrap[i] <= 1'b0;
            end
        end else begin
            // step level seen two edges ago high, three edges ago low
            edge_ev = hist[1] && !hist[2];
            hist   <= '{step, hist[0], hist[1]};
            for (int i = 0; i < 2; i++) begin
                c = m_cnt[i]; p = m_pos[i]; t = 1'b0; w = 1'b0; adv = 1'b0;
                if (mode) begin
                    c   = 0;
                    adv = en && edge_ev;
                end else if (en) begin
                    t   = (c == m_div[i] - 1);
                    c   = (c + 1) % m_div[i];
                    adv = t;
                end
                if (adv) begin
                    if (!dir) begin
                        if (p == m_len[i] + 2) begin p = 0; w = 1'b1; end
                        else p = p + 1;
                    end else begin
                        if (p == 0) begin p = m_len[i] + 2; w = 1'b1; end
                        else p = p - 1;
                    end
                end
                e_dig[i]  <= window(m_pos[i], m_len[i]);
                m_cnt[i]  <= c;
                m_pos[i]  <= p;
                e_tick[i] <= t;
                e_wrap[i] <= w;
            end
        end
    end

    always @(posedge clk) begin : compare
        #1;
        if (m_valid) begin
            chk("model_dig_a",  32'(bus_a.digits), 32'(e_dig[0]));
            chk("model_tick_a", 32'(bus_a.tick),   32'(e_tick[0]));
            chk("model_wrap_a", 32'(bus_a.wrap),   32'(e_wrap[0]));
            chk("model_dig_b",  32'(bus_b.digits), 32'(e_dig[1]));
            chk("model_tick_b", 32'(bus_b.tick),   32'(e_tick[1]));
            chk("model_wrap_b", 32'(bus_b.wrap),   32'(e_wrap[1]));
        end
    end

    task automatic do_reset(input logic d, input logic m);
        @(negedge clk);
        rst = 1'b1; dir = d; mode = m; en = 1'b1; step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_tick(input int which, output int n);
        logic tk;
        n  = 0;
        tk = 1'b0;
        while (!tk && n < 30) begin
            @(posedge clk); #1;
            n++;
            tk = (which == 0) ? bus_a.tick : bus_b.tick;
        end
        chk("tick_seen", 32'(tk), 32'd1);
    endtask

    logic [15:0] tbl_a [11] = '{16'hFFF0, 16'hFF01, 16'hF012, 16'h0123, 16'h1234, 16'h2345,
                                16'h3456, 16'h4567, 16'h567F, 16'h67FF, 16'h7FFF};
    logic [15:0] tbl_b [6]  = '{16'hFFF0, 16'hFF01, 16'hF012, 16'h012F, 16'h12FF, 16'h2FFF};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int tk;
        rst = 1'b1; en = 1'b1; mode = 1'b0; dir = 1'b0; step = 1'b0;

        // reset state and forward auto scroll, NAME_LEN=8
        do_reset(1'b0, 1'b0);
        chk("rst_digits", 32'(bus_a.digits), 32'h0000FFF0);
        chk("rst_tick",   32'(bus_a.tick),   32'd0);
        chk("rst_wrap",   32'(bus_a.wrap),   32'd0);
        for (int t = 1; t <= 11; t++) begin
            wait_tick(0, n);
            chk("fwd_gap", 32'(n), (t == 1) ? 32'd4 : 32'd3);
            chk("fwd_wrap", 32'(bus_a.wrap), (t == 11) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            chk("fwd_digits", 32'(bus_a.digits), 32'(tbl_a[t % 11]));
            chk("fwd_wrap_clear", 32'(bus_a.wrap), 32'd0);
        end

        // forward auto scroll, NAME_LEN=3, DIV=2
        do_reset(1'b0, 1'b0);
        for (int t = 1; t <= 6; t++) begin
            wait_tick(1, n);
            chk("short_gap", 32'(n), (t == 1) ? 32'd2 : 32'd1);
            chk("short_wrap", 32'(bus_b.wrap), (t == 6) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
            chk("short_digits", 32'(bus_b.digits), 32'(tbl_b[t % 6]));
        end

        // backward wrap from reset
        do_reset(1'b1, 1'b0);
        wait_tick(0, n);
        chk("bwd_wrap", 32'(bus_a.wrap), 32'd1);
        @(posedge clk); #1;
        chk("bwd_digits_last", 32'(bus_a.digits), 32'h00007FFF);
        chk("bwd_wrap_pulse",  32'(bus_a.wrap),   32'd0);
        wait_tick(0, n);
        chk("bwd_wrap2", 32'(bus_a.wrap), 32'd0);
        @(posedge clk); #1;
        chk("bwd_digits_9", 32'(bus_a.digits), 32'h000067FF);

        // switching manual -> auto starts a full interval
        do_reset(1'b0, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        chk("manual_no_tick", 32'(bus_a.tick), 32'd0);
        @(negedge clk);
        mode = 1'b0;
        wait_tick(0, n);
        chk("mode_switch_gap", 32'(n), 32'd4);

        // manual step: one advance per press, fixed latency, no ticks
        do_reset(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        step = 1'b1;
        tk = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus_a.tick) tk++;
        end
        chk("step_early", 32'(bus_a.digits), 32'h0000FFF0);
        @(posedge clk); #1;
        chk("step_latency", 32'(bus_a.digits), 32'h0000FF01);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (bus_a.tick) tk++;
        end
        @(negedge clk);
        step = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus_a.tick) tk++;
        end
        chk("step_once", 32'(bus_a.digits), 32'h0000FF01);
        chk("step_no_tick", 32'(tk), 32'd0);

        // press while disabled, still held at re-enable: no stale advance
        @(negedge clk);
        en = 1'b0; step = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
        step = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_stale_edge", 32'(bus_a.digits), 32'h0000FF01);
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        repeat (5) @(negedge clk);
        chk("second_press", 32'(bus_a.digits), 32'h0000F012);

        // en gating with prescaler frozen at 2
        do_reset(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        tk = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            step = ~step;
            if (bus_a.tick) tk++;
        end
        step = 1'b0;
        chk("en_hold_digits", 32'(bus_a.digits), 32'h0000FFF0);
        chk("en_hold_tick", 32'(tk), 32'd0);
        en = 1'b1;
        @(posedge clk); #1;
        chk("reen_cycle1", 32'(bus_a.tick), 32'd0);
        @(posedge clk); #1;
        chk("reen_cycle2", 32'(bus_a.tick), 32'd1);

        // reset coincident with terminal count at pos=5
        do_reset(1'b0, 1'b0);
        repeat (5) wait_tick(0, n);
        @(posedge clk); #1;
        chk("pre_rst_digits", 32'(bus_a.digits), 32'h00002345);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_digits", 32'(bus_a.digits), 32'h0000FFF0);
        chk("mid_rst_tick",   32'(bus_a.tick),   32'd0);
        chk("mid_rst_wrap",   32'(bus_a.wrap),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(0, n);
        chk("post_rst_gap", 32'(n), 32'd4);
        @(posedge clk); #1;
        chk("post_rst_digits", 32'(bus_a.digits), 32'h0000FF01);

        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
